// File: rtl/sd_pio_pkg.sv
// Shared register offsets, edge-capture mode encodings and timing constants
// for the bidirectional PIO block.
package sd_pio_pkg;

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_DIR     = 3'd1,
    REG_IRQMASK = 3'd2,
    REG_EDGECAP = 3'd3,
    REG_OUTSET  = 3'd4,
    REG_OUTCLR  = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } pio_reg_e;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // Capture stays blocked this many edges after reset so the pipeline refills first.
  localparam logic [1:0] HOLDOFF_CYCLES = 2'd3;

endpackage

// File: rtl/sd_pio_sync.sv
// Two-stage synchronizer bringing the asynchronous pad inputs into the clk domain.
module sd_pio_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/sd_bidir_pio.sv
// Avalon-MM bidirectional PIO: data/direction registers, set/clear aliases,
// synchronized inputs with per-bit edge capture and a masked level interrupt.
module sd_bidir_pio
  import sd_pio_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] DATA_RESET = '0,
  parameter logic [WIDTH-1:0] DIR_RESET  = '0,
  parameter int               EDGE_TYPE  = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] pio_in,
  output logic [WIDTH-1:0] pio_out,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] r_dataOut;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_irqMask;
  logic [WIDTH-1:0] r_edgeCap;
  logic [WIDTH-1:0] r_inPrev;
  logic [31:0]      r_readdata;
  logic             r_irq;
  logic [1:0]       r_holdCnt;

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_inSync;
  logic [WIDTH-1:0] w_edges;
  logic [WIDTH-1:0] w_capClr;
  logic [WIDTH-1:0] w_readVal;
  logic [31:0]      w_readExt;
  logic             w_capEn;
  logic             w_unused;

  sd_pio_sync #(.WIDTH(WIDTH)) u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (pio_in),
    .o_sync  (w_inSync)
  );

  assign w_wr     = chipselect & ~write_n;
  assign w_rd     = chipselect & ~read_n;
  assign w_wdata  = writedata[WIDTH-1:0];
  assign w_unused = ^writedata;
  assign w_capEn  = (r_holdCnt == 2'd0);
  assign w_capClr = (w_wr && (pio_reg_e'(address) == REG_EDGECAP)) ? w_wdata : '0;

  always_comb begin
    w_edges = w_inSync & ~r_inPrev;
    if (EDGE_TYPE == EDGE_FALLING) begin
      w_edges = ~w_inSync & r_inPrev;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      w_edges = w_inSync ^ r_inPrev;
    end
  end

  // Output-direction bits read back the driven value, input bits the synchronized pad.
  always_comb begin
    w_readVal = '0;
    case (pio_reg_e'(address))
      REG_DATA:    w_readVal = (r_dataOut & r_dir) | (w_inSync & ~r_dir);
      REG_DIR:     w_readVal = r_dir;
      REG_IRQMASK: w_readVal = r_irqMask;
      REG_EDGECAP: w_readVal = r_edgeCap;
      default:     w_readVal = '0;
    endcase
    w_readExt = '0;
    w_readExt[WIDTH-1:0] = w_readVal;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dataOut  <= DATA_RESET;
      r_dir      <= DIR_RESET;
      r_irqMask  <= '0;
      r_edgeCap  <= '0;
      r_inPrev   <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
      r_holdCnt  <= HOLDOFF_CYCLES;
    end else begin
      if (w_wr) begin
        case (pio_reg_e'(address))
          REG_DATA:    r_dataOut <= w_wdata;
          REG_DIR:     r_dir     <= w_wdata;
          REG_IRQMASK: r_irqMask <= w_wdata;
          REG_OUTSET:  r_dataOut <= r_dataOut | w_wdata;
          REG_OUTCLR:  r_dataOut <= r_dataOut & ~w_wdata;
          default:     ;
        endcase
      end
      if (w_rd) begin
        r_readdata <= w_readExt;
      end
      // A fresh edge wins over a simultaneous write-1-to-clear of the same bit.
      r_edgeCap <= (r_edgeCap & ~w_capClr) | (w_edges & {WIDTH{w_capEn}});
      r_irq     <= |(r_edgeCap & r_irqMask);
      r_inPrev  <= w_inSync;
      if (r_holdCnt != 2'd0) begin
        r_holdCnt <= r_holdCnt - 2'd1;
      end
    end
  end

  assign readdata = r_readdata;
  assign irq      = r_irq;
  assign pio_out  = r_dataOut;
  assign pio_oe   = r_dir;

endmodule

// File: tb/tb_sd_bidir_pio.sv
// Randomized and directed bench for sd_bidir_pio, checked every cycle against
// a delay-line reference model of the register map and edge capture.
module tb_sd_bidir_pio;
  import sd_pio_pkg::*;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        writeN;
  logic        readN;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  pioIn;
  logic [7:0]  pioOut;
  logic [7:0]  pioOe;
  logic        irq;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  logic [7:0]  mData, mDir, mMask, mCap;
  logic        mIrq;
  logic [31:0] mRead;
  logic [7:0]  padHist [3];
  int          mSince;
  logic [7:0]  curPin;

  sd_bidir_pio #(
    .WIDTH      (8),
    .DATA_RESET (8'h00),
    .DIR_RESET  (8'h00),
    .EDGE_TYPE  (EDGE_RISING)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (writeN),
    .read_n     (readN),
    .writedata  (writedata),
    .readdata   (readdata),
    .pio_in     (pioIn),
    .pio_out    (pioOut),
    .pio_oe     (pioOe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // The pad value seen at an edge reaches in_sync two edges later and in_prev three.
  task automatic modelStep(input logic rst, input logic cs, input logic wr, input logic rd,
                           input logic [2:0] addr, input logic [31:0] wd, input logic [7:0] pin);
    logic [7:0] sync, prev, w, ev, rv, clr;
    logic       nIrq;
    if (rst) begin
      mData = 8'h00; mDir = 8'h00; mMask = 8'h00; mCap = 8'h00;
      mIrq = 1'b0; mRead = 32'h0; mSince = 0;
      padHist[0] = 8'h00; padHist[1] = 8'h00; padHist[2] = 8'h00;
      return;
    end
    mSince++;
    sync = padHist[1];
    prev = padHist[2];
    w    = wd[7:0];
    ev   = sync & ~prev;
    clr  = 8'h00;
    nIrq = |(mCap & mMask);
    if (cs && rd) begin
      case (addr)
        3'd0:    rv = (mData & mDir) | (sync & ~mDir);
        3'd1:    rv = mDir;
        3'd2:    rv = mMask;
        3'd3:    rv = mCap;
        default: rv = 8'h00;
      endcase
      mRead = {24'h0, rv};
    end
    if (cs && wr) begin
      case (addr)
        3'd0: mData = w;
        3'd1: mDir  = w;
        3'd2: mMask = w;
        3'd3: clr   = w;
        3'd4: mData = mData | w;
        3'd5: mData = mData & ~w;
        default: ;
      endcase
    end
    mCap = (mCap & ~clr) | ((mSince > 3) ? ev : 8'h00);
    mIrq = nIrq;
    padHist[2] = padHist[1];
    padHist[1] = padHist[0];
    padHist[0] = pin;
  endtask

  task automatic applyStimulus(input logic rst, input logic cs, input logic wr, input logic rd,
                               input logic [2:0] addr, input logic [31:0] wd, input logic [7:0] pin);
    reset      = rst;
    chipselect = cs;
    writeN     = ~wr;
    readN      = ~rd;
    address    = addr;
    writedata  = wd;
    pioIn      = pin;
    curPin     = pin;
    @(posedge clk);
    modelStep(rst, cs, wr, rd, addr, wd, pin);
    #1;
    checkOutput("readdata", readdata, mRead);
    checkOutput("pio_out", {24'h0, pioOut}, {24'h0, mData});
    checkOutput("pio_oe", {24'h0, pioOe}, {24'h0, mDir});
    checkOutput("irq", {31'h0, irq}, {31'h0, mIrq});
  endtask

  task automatic writeReg(input logic [2:0] addr, input logic [31:0] wd);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, addr, wd, curPin);
  endtask

  task automatic readReg(input logic [2:0] addr);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, addr, $urandom, curPin);
  endtask

  task automatic idle(input logic [7:0] pin, input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, pin);
  endtask

  initial begin
    curPin = 8'h00;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'h00);
    checkOutput("rst_oe", {24'h0, pioOe}, 32'h0);
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      readReg(3'(a));
      checkOutput("rst_read", readdata, 32'h0);
    end

    // Output set/clear aliases; upper writedata bits must be ignored
    writeReg(3'd1, 32'hFFFF_FFFF);
    writeReg(3'd0, 32'hABCD_000F);
    writeReg(3'd4, 32'h0000_0030);
    writeReg(3'd5, 32'h0000_0003);
    checkOutput("setclr_out", {24'h0, pioOut}, 32'h3C);
    readReg(3'd0);
    checkOutput("setclr_read", readdata, 32'h3C);
    writeReg(3'd6, 32'h55);
    readReg(3'd6);
    checkOutput("rsvd_read", readdata, 32'h0);

    // Mixed direction read-back
    writeReg(3'd1, 32'hF0);
    writeReg(3'd0, 32'hA5);
    idle(8'h3C, 3);
    readReg(3'd0);
    checkOutput("mixed_read", readdata, 32'hAC);

    // Rising-edge interrupt on bit 0
    idle(8'h00, 4);
    writeReg(3'd3, 32'hFF);
    writeReg(3'd2, 32'h01);
    idle(8'h01, 3);
    readReg(3'd3);
    checkOutput("irq_cap", readdata, 32'h01);
    checkOutput("irq_high", {31'h0, irq}, 32'h1);
    writeReg(3'd3, 32'h01);
    idle(8'h01, 1);
    checkOutput("irq_clr", {31'h0, irq}, 32'h0);

    // Edge on bit 2 collides with its clear
    idle(8'h00, 4);
    writeReg(3'd3, 32'hFF);
    idle(8'h04, 2);
    writeReg(3'd3, 32'h04);
    readReg(3'd3);
    checkOutput("collide_bit2", readdata & 32'h4, 32'h4);

    // Randomized traffic, including occasional resets
    for (int i = 0; i < 300; i++) begin
      logic [7:0] pin;
      pin = ($urandom_range(0, 3) == 0) ? 8'($urandom) : curPin;
      applyStimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
                    1'($urandom), 1'($urandom), 3'($urandom), $urandom, pin);
    end

    // Reset right after a read strobe, with interrupt pending and pads high
    writeReg(3'd2, 32'hFF);
    idle(8'h00, 4);
    writeReg(3'd3, 32'hFF);
    idle(8'h80, 4);
    checkOutput("pre_rst_irq", {31'h0, irq}, 32'h1);
    curPin = 8'hFF;
    readReg(3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 8'hFF);
    checkOutput("midrst_rdata", readdata, 32'h0);
    checkOutput("midrst_irq", {31'h0, irq}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      readReg(3'd3);
      checkOutput("holdoff_cap", readdata, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
